// File: rtl/text_pkg.sv
// text_pkg: shared constants and types for the character display writer path.
//   COLS/ROWS    - text grid size (640x480 pixels / 8x12 glyphs)
//   CELL_ADDR_W  - character RAM address width
//   BLANK        - code stored when clearing cells
//   CH_*         - control codes recognised by the writer
//   state_e      - writer sequencer states
package text_pkg;

  localparam int unsigned COLS        = 80;
  localparam int unsigned ROWS        = 40;
  localparam int unsigned CELLS       = COLS * ROWS;
  localparam int unsigned CELL_ADDR_W = 12;

  localparam logic [6:0] BLANK = 7'h20;
  localparam logic [6:0] CH_BS = 7'h08;
  localparam logic [6:0] CH_LF = 7'h0A;
  localparam logic [6:0] CH_FF = 7'h0C;
  localparam logic [6:0] CH_CR = 7'h0D;

  typedef enum logic [1:0] {
    CLEAR_ALL,
    IDLE,
    CLEAR_LINE
  } state_e;

endpackage

// File: rtl/cell_addr.sv
// cell_addr: combinational text-cell address, row*80 + col.
// Shared with the pixel-side fetch path.
//   i_row  - character row, 0..39
//   i_col  - character column, 0..79
//   o_addr - character RAM address
module cell_addr
  import text_pkg::*;
#(
  parameter int unsigned ADDR_W = CELL_ADDR_W
) (
  input  logic [5:0]        i_row,
  input  logic [6:0]        i_col,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;

  assign w_row = ADDR_W'(i_row);
  assign w_col = ADDR_W'(i_col);

  // row*80 = row*64 + row*16, widened first so nothing is truncated.
  assign o_addr = (w_row << 6) + (w_row << 4) + w_col;

endmodule

// File: rtl/text_writer.sv
// text_writer: writer side of the character display path. Accepts ASCII codes
// over valid/ready, tracks a text cursor, handles control codes and writes
// codes into the screen character RAM.
//   clock25    - single clock
//   reset_n    - asynchronous active-low reset; restarts a full-screen clear
//   char_in    - offered ASCII code; char_valid qualifies it
//   char_ready - high only in IDLE; transfer on char_valid && char_ready
//   wr_en/wr_addr/wr_data - one RAM cell write per cycle
//   cursor_col/cursor_row - current cursor position
//   busy       - high while a clear sequence runs
module text_writer
  import text_pkg::*;
#(
  parameter int unsigned COLS_P = COLS,  // cell_addr hardwires 80 columns
  parameter int unsigned ROWS_P = ROWS,
  parameter int unsigned ADDR_W = CELL_ADDR_W,
  parameter logic [6:0]  BLANK_P = BLANK
) (
  input  logic              clock25,
  input  logic              reset_n,
  input  logic [6:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [6:0]        wr_data,
  output logic [6:0]        cursor_col,
  output logic [5:0]        cursor_row,
  output logic              busy
);

  // One extra bit so the counter can reach the full cell count.
  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            r_state, w_state_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic              r_wr_en, w_wr_en_d;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_d;
  logic [6:0]        r_wr_data, w_wr_data_d;
  logic [6:0]        r_col, w_col_d;
  logic [5:0]        r_row, w_row_d;
  logic              r_ready, r_busy;

  logic              w_accept;
  logic              w_printable;
  logic              w_row_adv;
  logic [6:0]        w_addr_col;
  logic [ADDR_W-1:0] w_cell_addr;

  assign w_accept    = char_valid && r_ready;
  assign w_printable = (char_in >= 7'h20) && (char_in <= 7'h7E);

  // Column feeding the shared address calculator: line-clear counter, the
  // cell left of the cursor for backspace, otherwise the cursor itself.
  always_comb begin
    w_addr_col = r_col;
    if (r_state == CLEAR_LINE) begin
      w_addr_col = r_cnt[6:0];
    end else if (char_in == CH_BS) begin
      w_addr_col = r_col - 7'd1;
    end
  end

  cell_addr #(
    .ADDR_W(ADDR_W)
  ) u_cell_addr (
    .i_row (r_row),
    .i_col (w_addr_col),
    .o_addr(w_cell_addr)
  );

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_wr_en_d   = 1'b0;
    w_wr_addr_d = r_wr_addr;
    w_wr_data_d = r_wr_data;
    w_col_d     = r_col;
    w_row_d     = r_row;
    w_row_adv   = 1'b0;

    unique case (r_state)
      CLEAR_ALL: begin
        if (r_cnt < CNT_W'(COLS_P * ROWS_P)) begin
          w_wr_en_d   = 1'b1;
          w_wr_addr_d = r_cnt[ADDR_W-1:0];
          w_wr_data_d = BLANK_P;
          w_cnt_d     = r_cnt + CNT_W'(1);
        end else begin
          w_state_d = IDLE;
          w_cnt_d   = '0;
        end
      end

      CLEAR_LINE: begin
        if (r_cnt < CNT_W'(COLS_P)) begin
          w_wr_en_d   = 1'b1;
          w_wr_addr_d = w_cell_addr;
          w_wr_data_d = BLANK_P;
          w_cnt_d     = r_cnt + CNT_W'(1);
        end else begin
          w_state_d = IDLE;
          w_cnt_d   = '0;
        end
      end

      IDLE: begin
        if (w_accept) begin
          if (w_printable) begin
            w_wr_en_d   = 1'b1;
            w_wr_addr_d = w_cell_addr;
            w_wr_data_d = char_in;
            if (r_col == 7'(COLS_P - 1)) begin
              w_col_d   = '0;
              w_row_adv = 1'b1;
            end else begin
              w_col_d = r_col + 7'd1;
            end
          end else if (char_in == CH_CR) begin
            w_col_d = '0;
          end else if (char_in == CH_LF) begin
            w_col_d   = '0;
            w_row_adv = 1'b1;
          end else if (char_in == CH_BS) begin
            // No reverse wrap onto the previous row at column 0.
            if (r_col != '0) begin
              w_col_d     = r_col - 7'd1;
              w_wr_en_d   = 1'b1;
              w_wr_addr_d = w_cell_addr;
              w_wr_data_d = BLANK_P;
            end
          end else if (char_in == CH_FF) begin
            w_col_d   = '0;
            w_row_d   = '0;
            w_cnt_d   = '0;
            w_state_d = CLEAR_ALL;
          end
        end
      end

      default: begin
        w_state_d = CLEAR_ALL;
        w_cnt_d   = '0;
      end
    endcase

    // No scrolling: wrap to the top row and blank it before it is reused.
    if (w_row_adv) begin
      if (r_row == 6'(ROWS_P - 1)) begin
        w_row_d   = '0;
        w_col_d   = '0;
        w_cnt_d   = '0;
        w_state_d = CLEAR_LINE;
      end else begin
        w_row_d = r_row + 6'd1;
      end
    end
  end

  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= CLEAR_ALL;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= BLANK_P;
      r_col     <= '0;
      r_row     <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_wr_en   <= w_wr_en_d;
      r_wr_addr <= w_wr_addr_d;
      r_wr_data <= w_wr_data_d;
      r_col     <= w_col_d;
      r_row     <= w_row_d;
      // Registered from the next state so ready always equals (state == IDLE).
      r_ready   <= (w_state_d == IDLE);
      r_busy    <= (w_state_d != IDLE);
    end
  end

  assign char_ready = r_ready;
  assign busy       = r_busy;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cursor_col = r_col;
  assign cursor_row = r_row;

endmodule

// File: tb/tb_text_writer.sv
// Directed bench for text_writer: reset values, full clear, printable writes,
// control codes, bottom-right wrap with line clear, and async reset mid-clear.
module tb_text_writer;

  logic        clock25;
  logic        reset_n;
  logic [6:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [6:0]  wr_data;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  text_writer u_dut (
    .clock25   (clock25),
    .reset_n   (reset_n),
    .char_in   (char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy)
  );

  initial clock25 = 1'b0;
  always #5 clock25 = ~clock25;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock25);
    #1;
  endtask

  // Offer one code for one edge; caller knows char_ready is high.
  task automatic send(input logic [6:0] c);
    char_in    = c;
    char_valid = 1'b1;
    tick();
    char_valid = 1'b0;
  endtask

  // Starts with state CLEAR_ALL and counter 0: expect 3200 writes then ready.
  task automatic check_full_clear(input string tag);
    int bad = 0;
    for (int i = 0; i < 3200; i++) begin
      tick();
      if (wr_en !== 1'b1 || wr_addr !== 12'(i) || wr_data !== 7'h20 ||
          char_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    check_eq({tag, "_bad_cycles"}, bad, 0);
    check_eq({tag, "_last_addr"}, wr_addr, 3199);
    tick();
    check_eq({tag, "_ready"}, char_ready, 1);
    check_eq({tag, "_wr_en_off"}, wr_en, 0);
    check_eq({tag, "_busy_off"}, busy, 0);
    check_eq({tag, "_col"}, cursor_col, 0);
    check_eq({tag, "_row"}, cursor_row, 0);
  endtask

  initial begin
    int bad;
    reset_n    = 1'b0;
    char_in    = 7'h00;
    char_valid = 1'b0;
    repeat (3) tick();

    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 7'h20);
    check_eq("rst_ready", char_ready, 0);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_col", cursor_col, 0);
    check_eq("rst_row", cursor_row, 0);

    reset_n = 1'b1;
    check_full_clear("init");

    // "AB" back to back.
    char_in    = 7'h41;
    char_valid = 1'b1;
    tick();
    check_eq("A_wr_en", wr_en, 1);
    check_eq("A_addr", wr_addr, 0);
    check_eq("A_data", wr_data, 7'h41);
    char_in = 7'h42;
    tick();
    char_valid = 1'b0;
    check_eq("B_wr_en", wr_en, 1);
    check_eq("B_addr", wr_addr, 1);
    check_eq("B_data", wr_data, 7'h42);
    check_eq("AB_col", cursor_col, 2);
    tick();
    check_eq("AB_idle_wr_en", wr_en, 0);

    // Move to col 5 row 2 and exercise backspace / CR.
    send(7'h0A);
    send(7'h0A);
    for (int i = 0; i < 5; i++) send(7'h61 + 7'(i));
    check_eq("pos_col5", cursor_col, 5);
    check_eq("pos_row2", cursor_row, 2);
    send(7'h08);
    check_eq("bs_wr_en", wr_en, 1);
    check_eq("bs_addr", wr_addr, 164);
    check_eq("bs_data", wr_data, 7'h20);
    check_eq("bs_col", cursor_col, 4);
    send(7'h0D);
    check_eq("cr_wr_en", wr_en, 0);
    check_eq("cr_col", cursor_col, 0);
    check_eq("cr_row", cursor_row, 2);
    send(7'h08);
    check_eq("bs0_wr_en", wr_en, 0);
    check_eq("bs0_col", cursor_col, 0);
    check_eq("bs0_row", cursor_row, 2);
    send(7'h7F);
    check_eq("del_wr_en", wr_en, 0);
    check_eq("del_col", cursor_col, 0);

    // Form feed back to home, then fill row 0 and wrap.
    send(7'h0C);
    check_eq("ff_col", cursor_col, 0);
    check_eq("ff_row", cursor_row, 0);
    check_eq("ff_busy", busy, 1);
    check_eq("ff_ready", char_ready, 0);
    check_full_clear("ff");
    for (int i = 0; i < 79; i++) send(7'h2E);
    send(7'h5A);
    check_eq("Z_wr_en", wr_en, 1);
    check_eq("Z_addr", wr_addr, 79);
    check_eq("Z_data", wr_data, 7'h5A);
    check_eq("Z_col", cursor_col, 0);
    check_eq("Z_row", cursor_row, 1);
    send(7'h0A);
    check_eq("lf_wr_en", wr_en, 0);
    check_eq("lf_col", cursor_col, 0);
    check_eq("lf_row", cursor_row, 2);

    // Reach (79,39) then print 'Q'.
    for (int i = 0; i < 37; i++) send(7'h0A);
    for (int i = 0; i < 79; i++) send(7'h2A);
    check_eq("br_col", cursor_col, 79);
    check_eq("br_row", cursor_row, 39);
    send(7'h51);
    check_eq("Q_wr_en", wr_en, 1);
    check_eq("Q_addr", wr_addr, 3199);
    check_eq("Q_data", wr_data, 7'h51);
    check_eq("Q_ready", char_ready, 0);
    check_eq("Q_col", cursor_col, 0);
    check_eq("Q_row", cursor_row, 0);
    // Producer holds 'X' through the line clear; it must land afterwards.
    char_in    = 7'h58;
    char_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (wr_en !== 1'b1 || wr_addr !== 12'(i) || wr_data !== 7'h20 ||
          char_ready !== 1'b0 || busy !== 1'b1 || cursor_col !== 7'd0) bad++;
    end
    check_eq("cl_bad_cycles", bad, 0);
    tick();
    check_eq("cl_done_ready", char_ready, 1);
    check_eq("cl_done_wr_en", wr_en, 0);
    tick();
    char_valid = 1'b0;
    check_eq("X_wr_en", wr_en, 1);
    check_eq("X_addr", wr_addr, 0);
    check_eq("X_data", wr_data, 7'h58);
    check_eq("X_col", cursor_col, 1);

    // FF then async reset in the middle of the clear.
    send(7'h0C);
    repeat (100) tick();
    check_eq("mid_clear_addr", wr_addr, 99);
    check_eq("mid_clear_wr_en", wr_en, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_wr_en", wr_en, 0);
    check_eq("arst_addr", wr_addr, 0);
    check_eq("arst_data", wr_data, 7'h20);
    check_eq("arst_busy", busy, 1);
    check_eq("arst_ready", char_ready, 0);
    tick();
    reset_n = 1'b1;
    check_full_clear("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
